// File: rtl/fifo_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_tx_pkg;

    typedef enum logic [2:0] {IDLE, POP, LATCH, START, DATA, STOP} tx_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic TX_IDLE   = 1'b1;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: ticks in the last clock of each bit, restarts on clear.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (!rst || clear || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the upstream FIFO and serializes them as 8N1 (or 8N2) UART frames.
module fifo_uart_tx
    import fifo_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    tx_state_t            state, state_nx;
    logic                 tx_nx, rd_nx;
    logic [DATA_BITS-1:0] shift, shift_nx;
    logic [2:0]           bit_idx, idx_nx;
    logic                 tick, clear;

    baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clock(clock),
        .rst  (rst),
        .clear(clear),
        .tick (tick)
    );

    always_comb begin
        state_nx  = state;
        tx_nx     = tx;
        rd_nx     = 1'b0;
        shift_nx  = shift;
        idx_nx    = bit_idx;
        byte_done = 1'b0;
        case (state)
            IDLE: begin
                tx_nx = TX_IDLE;
                if (enable && !fifo_empty) begin
                    rd_nx    = 1'b1;
                    state_nx = POP;
                end
            end
            POP:   state_nx = LATCH;
            // FIFO data_out is valid here, one cycle after the rd strobe was sampled
            LATCH: begin
                shift_nx = fifo_data;
                tx_nx    = 1'b0;
                idx_nx   = '0;
                state_nx = START;
            end
            START: begin
                if (tick) begin
                    tx_nx    = shift[0];
                    shift_nx = {1'b0, shift[DATA_BITS-1:1]};
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == LAST_BIT) begin
                        tx_nx    = TX_IDLE;
                        idx_nx   = '0;
                        state_nx = STOP;
                    end else begin
                        tx_nx    = shift[0];
                        shift_nx = {1'b0, shift[DATA_BITS-1:1]};
                        idx_nx   = bit_idx + 1'b1;
                    end
                end
            end
            // bit_idx is reused to count stop bits
            STOP: begin
                if (tick) begin
                    if (bit_idx == LAST_STOP) begin
                        byte_done = 1'b1;
                        state_nx  = IDLE;
                    end else begin
                        idx_nx = bit_idx + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        clear = (state_nx != state);
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            state   <= IDLE;
            tx      <= TX_IDLE;
            fifo_rd <= 1'b0;
            shift   <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_nx;
            tx      <= tx_nx;
            fifo_rd <= rd_nx;
            shift   <= shift_nx;
            bit_idx <= idx_nx;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream drain stage for the 32x8 byte FIFO. It pops one byte at a time using the FIFO's rd/empty/data_out interface and serializes each byte onto a UART line as 8N1, with optional 2 stop bits. The FIFO returns data_out registered one cycle after rd is sampled; this block's pop sequence is timed to that.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit; legal range is 2..65535.
STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
clock  input  1  single system clock; all logic is on the rising edge.
rst  input  1  reset, synchronous and active-low (0 = reset).
enable  input  1  allows a new pop/transmit; sampled only in IDLE.
fifo_empty  input  1  FIFO empty flag.
fifo_data  input  8  FIFO data_out.
fifo_rd  output  1  FIFO read strobe; registered; exactly a 1-cycle pulse per byte.
tx  output  1  serial line; idles high.
busy  output  1  high whenever state != IDLE.
byte_done  output  1  1-cycle pulse in the last cycle of the final stop bit.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, tx=1, fifo_rd=0, busy=0, byte_done=0, baud counter=0, bit index=0, shift register=0.
- Reset mid-byte: tx=1 from the next edge. The popped byte is discarded, and no further fifo_rd is issued until rst=1.
- FSM states: IDLE, POP, LATCH, START, DATA, STOP.
- IDLE: if enable=1 and fifo_empty=0, then fifo_rd<=1 and go to POP. Otherwise hold with tx=1.
- POP: fifo_rd<=0, go to LATCH. The FIFO samples rd=1 at this edge and updates data_out.
- LATCH: shift register<=fifo_data, go to START. fifo_empty is not consulted here.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held for CLKS_PER_BIT cycles. Bit index runs 0..7 and is 3 bits wide.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. byte_done=1 in the final cycle, then go to IDLE.
- tx is driven from a register (glitch-free). The transition into START drives tx=0 at the LATCH->START edge.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and clears on every state change.
- Frame length, first START cycle to last STOP cycle: (1+8+STOP_BITS)*CLKS_PER_BIT cycles.
- Back-to-back bytes: the IDLE, POP and LATCH cycles add 3 extra tx-high cycles between frames.
- enable deasserted mid-frame: the current frame completes, then the block stays in IDLE.
- fifo_empty rising mid-frame has no effect.
- fifo_rd is never asserted when fifo_empty=1 at the IDLE edge, and never twice for the same byte.

Decomposition:
- Package fifo_tx_pkg holds:
  - typedef enum logic [2:0] tx_state_t {IDLE, POP, LATCH, START, DATA, STOP};
  - localparam DATA_BITS = 8;
  - localparam TX_IDLE = 1'b1.
- One sub-module: baud_tick_gen (params CLKS_PER_BIT; ports clock, rst, clear, tick).
  - tick pulses when the counter reaches CLKS_PER_BIT-1.
- The FSM and shift register remain in fifo_uart_tx.

Test Plan:
1. Reset, with CLKS_PER_BIT=4: hold rst=0 for 3 cycles -> tx=1, fifo_rd=0, busy=0, byte_done=0.
2. Single byte: FIFO holds 0xA5, enable=1 ->
   - one fifo_rd pulse;
   - tx shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit 4 cycles;
   - byte_done pulses once, 40 cycles after START begins.
3. Back-to-back: FIFO holds 0x00 then 0xFF -> two frames, two fifo_rd pulses, exactly 3 extra tx-high cycles between frames.
4. Empty FIFO: fifo_empty=1, enable=1 for 100 cycles -> fifo_rd is never asserted, tx stays 1, busy=0.
5. Mid-frame events:
   - enable drops during DATA of 0x3C -> the frame completes and no further pop occurs.
   - rst=0 asserted during bit 3 -> tx=1 at the next edge, state=IDLE.
6. STOP_BITS=2, byte 0x81 -> stop phase lasts 8 cycles and the frame is 44 cycles.
